// File: rtl/echo_tester.sv
// echo_tester: host-side UART echo initiator. Sends one 8N1 byte on txd,
// waits for the far-end echo on rxd, deserialises it and reports
// match / mismatch / framing / timeout, keeping a saturating error count.
module echo_tester #(
  parameter int CLKS_PER_BIT = 5208,
  parameter int TIMEOUT_BITS = 40
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [7:0] tx_word,
  input  logic       rxd,
  output logic       txd,
  output logic       busy,
  output logic       done,
  output logic       match,
  output logic       timeout,
  output logic [7:0] rx_word,
  output logic [7:0] err_count
);

  localparam int TMO_CYCLES = TIMEOUT_BITS * CLKS_PER_BIT;
  localparam int CNT_W      = $clog2(TMO_CYCLES + 1);

  localparam logic [CNT_W-1:0] CNT_ZERO = '0;
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] BIT_LD   = CNT_W'(CLKS_PER_BIT);
  localparam logic [CNT_W-1:0] HALF_LD  = CNT_W'(CLKS_PER_BIT / 2);
  localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'(TMO_CYCLES - 1);

  typedef enum logic [2:0] {
    IDLE,
    SEND,
    WAIT_ECHO,
    RECV,
    REPORT
  } state_t;

  state_t           state;
  logic [CNT_W-1:0] bit_cnt;
  logic [CNT_W-1:0] tmo_cnt;
  logic [3:0]       bit_idx;
  logic             pend;
  logic [8:0]       tx_shift;
  logic [7:0]       tx_lat;
  logic [7:0]       rx_shift;

  logic             rxd_meta;
  logic             rxd_sync;
  logic             rxd_prev;
  logic             rxd_fall;
  logic             echo_ok;

  // Saturating increment for the error counter.
  function automatic logic [7:0] sat_inc(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  assign rxd_fall = rxd_prev & ~rxd_sync;
  // Evaluated on the stop-bit sample: byte must match and stop bit must be 1.
  assign echo_ok  = (rx_shift == tx_lat) && rxd_sync;

  // Two-flop synchroniser for rxd plus a delayed copy for edge detection.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rxd_meta <= 1'b1;
      rxd_sync <= 1'b1;
      rxd_prev <= 1'b1;
    end else begin
      rxd_meta <= rxd;
      rxd_sync <= rxd_meta;
      rxd_prev <= rxd_sync;
    end
  end

  // Transaction FSM: serialise, wait for echo start, deserialise, report.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      bit_cnt   <= CNT_ZERO;
      tmo_cnt   <= CNT_ZERO;
      bit_idx   <= 4'd0;
      pend      <= 1'b0;
      tx_shift  <= 9'h1FF;
      tx_lat    <= 8'h00;
      rx_shift  <= 8'h00;
      txd       <= 1'b1;
      busy      <= 1'b0;
      done      <= 1'b0;
      match     <= 1'b0;
      timeout   <= 1'b0;
      rx_word   <= 8'h00;
      err_count <= 8'h00;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            tx_lat   <= tx_word;
            tx_shift <= {1'b1, tx_word};
            match    <= 1'b0;
            timeout  <= 1'b0;
            rx_word  <= 8'h00;
            busy     <= 1'b1;
            txd      <= 1'b0;
            bit_cnt  <= BIT_LD;
            bit_idx  <= 4'd0;
            state    <= SEND;
          end
        end

        SEND: begin
          // bit_cnt counts down; ==1 marks the last cycle of the current bit.
          if (bit_cnt == CNT_ONE) begin
            bit_cnt <= BIT_LD;
            if (bit_idx == 4'd9) begin
              tmo_cnt <= CNT_ZERO;
              pend    <= 1'b0;
              state   <= WAIT_ECHO;
            end else begin
              txd      <= tx_shift[0];
              tx_shift <= {1'b1, tx_shift[8:1]};
              bit_idx  <= bit_idx + 4'd1;
            end
          end else begin
            bit_cnt <= bit_cnt - CNT_ONE;
          end
        end

        WAIT_ECHO: begin
          // Timeout counter parks at its last value so a pending start-bit
          // check can still complete before the timeout is declared.
          if (tmo_cnt != TMO_LAST) begin
            tmo_cnt <= tmo_cnt + CNT_ONE;
          end
          if (pend) begin
            if (bit_cnt == CNT_ONE) begin
              pend <= 1'b0;
              if (!rxd_sync) begin
                bit_cnt <= BIT_LD;
                bit_idx <= 4'd0;
                state   <= RECV;
              end
            end else begin
              bit_cnt <= bit_cnt - CNT_ONE;
            end
          end else if (tmo_cnt == TMO_LAST) begin
            timeout   <= 1'b1;
            match     <= 1'b0;
            done      <= 1'b1;
            err_count <= sat_inc(err_count);
            state     <= REPORT;
          end else if (rxd_fall) begin
            pend    <= 1'b1;
            bit_cnt <= HALF_LD;
          end
        end

        RECV: begin
          // Samples land one bit period apart, starting mid start-bit.
          if (bit_cnt == CNT_ONE) begin
            bit_cnt <= BIT_LD;
            if (bit_idx == 4'd8) begin
              rx_word <= rx_shift;
              match   <= echo_ok;
              done    <= 1'b1;
              if (!echo_ok) begin
                err_count <= sat_inc(err_count);
              end
              state <= REPORT;
            end else begin
              rx_shift <= {rxd_sync, rx_shift[7:1]};
              bit_idx  <= bit_idx + 4'd1;
            end
          end else begin
            bit_cnt <= bit_cnt - CNT_ONE;
          end
        end

        REPORT: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= IDLE;
        end

        default: begin
          state <= IDLE;
          busy  <= 1'b0;
          done  <= 1'b0;
          txd   <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_echo_tester.sv
// tb_echo_tester: scoreboard bench for echo_tester with CLKS_PER_BIT=4,
// TIMEOUT_BITS=40. Each transaction pushes its expected report; a monitor
// pops and compares on every done pulse.
`timescale 1ns/1ps
module tb_echo_tester;

  localparam int CPB = 4;
  localparam int TB  = 40;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       start;
  logic [7:0] tx_word;
  logic       rxd;
  logic       txd;
  logic       busy;
  logic       done;
  logic       match;
  logic       timeout;
  logic [7:0] rx_word;
  logic [7:0] err_count;

  typedef struct packed {
    logic       m;
    logic       t;
    logic [7:0] w;
    logic [7:0] e;
  } exp_t;

  exp_t       sb[$];
  int         n_cmp = 0;
  int         n_err = 0;
  logic [7:0] err_exp = 8'h00;
  int         lat;

  echo_tester #(.CLKS_PER_BIT(CPB), .TIMEOUT_BITS(TB)) dut (
    .clk       (clk),
    .rst       (rst_n),
    .start     (start),
    .tx_word   (tx_word),
    .rxd       (rxd),
    .txd       (txd),
    .busy      (busy),
    .done      (done),
    .match     (match),
    .timeout   (timeout),
    .rx_word   (rx_word),
    .err_count (err_count)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Scoreboard monitor: every done pulse must match the oldest expectation.
  always @(negedge clk) begin
    if (rst_n && done) begin
      if (sb.size() == 0) begin
        check("unexpected_done", 32'd1, 32'd0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("match", match, e.m);
        check("timeout", timeout, e.t);
        check("rx_word", rx_word, e.w);
        check("err_count", err_count, e.e);
        check("busy_at_done", busy, 1'b1);
      end
    end
  end

  task automatic run_txn(input logic [7:0] tx, input logic [7:0] echo, input bit do_echo,
                         input bit stop_v, input int gap, input bit glitch, input bit poke,
                         output int l);
    exp_t       e;
    bit         ok;
    logic [9:0] fr;
    logic [9:0] ef;
    if (do_echo) begin
      ok  = (echo == tx) && stop_v;
      e.m = ok;
      e.t = 1'b0;
      e.w = echo;
    end else begin
      ok  = 1'b0;
      e.m = 1'b0;
      e.t = 1'b1;
      e.w = 8'h00;
    end
    if (!ok && err_exp != 8'hFF) err_exp = err_exp + 8'd1;
    e.e = err_exp;
    sb.push_back(e);
    fr = {1'b1, tx, 1'b0};
    ef = {stop_v, echo, 1'b0};

    tx_word = tx;
    start   = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("busy_set", busy, 1'b1);
    for (int i = 0; i < 10; i++) begin
      repeat (2) @(negedge clk);
      check($sformatf("txd_bit%0d", i), txd, fr[i]);
      if (poke && i == 3) begin
        start   = 1'b1;
        tx_word = ~tx;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
      end else begin
        repeat (2) @(negedge clk);
      end
    end

    if (glitch) begin
      repeat (4) @(negedge clk);
      rxd = 1'b0;
      @(negedge clk);
      rxd = 1'b1;
      repeat (8) @(negedge clk);
    end
    if (do_echo) begin
      repeat (gap * CPB) @(negedge clk);
      for (int i = 0; i < 10; i++) begin
        rxd = ef[i];
        repeat (CPB) @(negedge clk);
      end
      rxd = 1'b1;
    end

    l = 0;
    while (!done && l < 400) begin
      @(negedge clk);
      l++;
    end
    check("done_seen", done, 1'b1);
    // A start pulse during the report cycle must be ignored.
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("busy_drop", busy, 1'b0);
    check("txd_idle", txd, 1'b1);
  endtask

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n   = 1'b0;
    start   = 1'b0;
    rxd     = 1'b1;
    tx_word = 8'h00;
    repeat (3) @(negedge clk);
    check("rst_txd", txd, 1'b1);
    check("rst_busy", busy, 1'b0);
    check("rst_done", done, 1'b0);
    check("rst_match", match, 1'b0);
    check("rst_timeout", timeout, 1'b0);
    check("rst_rx_word", rx_word, 8'h00);
    check("rst_err", err_count, 8'h00);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // 1: matching echo
    run_txn(8'hA5, 8'hA5, 1'b1, 1'b1, 2, 1'b0, 1'b0, lat);
    // 2: wrong byte echoed
    run_txn(8'hA5, 8'h5A, 1'b1, 1'b1, 2, 1'b0, 1'b0, lat);
    // 3: silent line -> timeout 160 cycles after own stop bit
    run_txn(8'h3C, 8'h00, 1'b0, 1'b1, 0, 1'b0, 1'b0, lat);
    check("tmo_latency", lat, TB * CPB);
    // 4: one-cycle glitch in WAIT, then a good echo
    run_txn(8'h3C, 8'h3C, 1'b1, 1'b1, 2, 1'b1, 1'b0, lat);
    // 5: framing error, then drive the counter into saturation
    run_txn(8'h3C, 8'h3C, 1'b1, 1'b0, 2, 1'b0, 1'b0, lat);
    while (err_exp != 8'hFF) begin
      run_txn(8'h11, 8'h00, 1'b0, 1'b1, 0, 1'b0, 1'b0, lat);
    end
    run_txn(8'h3C, 8'h3D, 1'b1, 1'b1, 1, 1'b0, 1'b0, lat);
    // 6: start pulse during SEND ignored
    run_txn(8'h96, 8'h96, 1'b1, 1'b1, 2, 1'b0, 1'b1, lat);
    // 6: reset mid-SEND
    tx_word = 8'h81;
    start   = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (12) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("midrst_txd", txd, 1'b1);
    check("midrst_busy", busy, 1'b0);
    check("midrst_done", done, 1'b0);
    check("midrst_err", err_count, 8'h00);
    @(negedge clk);
    rst_n   = 1'b1;
    err_exp = 8'h00;
    repeat (2) @(negedge clk);
    run_txn(8'hC3, 8'hC3, 1'b1, 1'b1, 2, 1'b0, 1'b0, lat);

    repeat (5) @(negedge clk);
    check("sb_drained", sb.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/echo_tester.md
Name: echo_tester

Overview:
- Host-side initiator for the UART echo path. Sends one 8N1 byte on txd and waits for the far-end echo on rxd.
- Deserialises the echo, compares it with the byte sent, and reports match, mismatch or timeout.
- Sits opposite the board-level echo responder. Used for link self-test and for the regression bench.

Parameters:
CLKS_PER_BIT, 5208, clk cycles per UART bit (50 MHz / 9600 baud); must be >= 4
TIMEOUT_BITS, 40, bit periods allowed between end of own stop bit and echo start-bit detection

Ports:
clk  in  1  system clock; the only clock
rst  in  1  reset, asynchronous, active-low
start  in  1  request one test transaction; sampled only in IDLE
tx_word  in  8  byte to send; captured on the accepted start cycle
rxd  in  1  serial input from far end; asynchronous; idle high
txd  out  1  serial output to far end; idle high
busy  out  1  high from the cycle after start is accepted until the done cycle, inclusive
done  out  1  one-cycle pulse; transaction finished
match  out  1  echo equal to sent byte and stop bit valid; held until next accepted start
timeout  out  1  no echo start bit within the window; held until next accepted start
rx_word  out  8  last received echo byte; held until next accepted start
err_count  out  8  count of mismatch, framing and timeout results; saturates at 255

Behaviour:
- Clock and reset: one clock; reset is asynchronous and active-low. Asserting rst immediately forces the values below, including mid-transfer; no partial result is reported.
- Reset values: txd=1, busy=0, done=0, match=0, timeout=0, rx_word=0, err_count=0, FSM=IDLE, all counters 0.
- rxd synchroniser: two flops (reset to 1). All RX logic uses the synchronised value.
- IDLE: on start=1, latch tx_word; clear match, timeout and rx_word; go to SEND. start is ignored in every other state.
- SEND: txd drives start bit 0, then data bits LSB first, then stop bit 1. Each bit lasts exactly CLKS_PER_BIT cycles. The start bit begins on the cycle after start is accepted. After the last stop-bit cycle, clear the timeout counter and go to WAIT.
- WAIT:
  - A falling edge on synchronised rxd loads the bit counter with CLKS_PER_BIT/2 (integer division).
  - At that mid-bit point, if rxd is still 0, go to RECV. Otherwise treat it as a glitch and stay in WAIT; the timeout counter keeps running.
  - When the timeout counter reaches TIMEOUT_BITS*CLKS_PER_BIT, set timeout=1 and go to REPORT.
- RECV: sample 8 data bits, then the stop bit, each CLKS_PER_BIT after the previous sample (mid-bit), shifting LSB first. After the stop-bit sample, go to REPORT.
- REPORT (one cycle):
  - done=1, rx_word = shifted byte.
  - match=1 only if the byte equals the latched tx_word and the stop sample = 1.
  - Otherwise (mismatch, framing error or timeout) err_count increments, saturating at 255.
  - Next state is IDLE; busy drops the following cycle.
- Start pulse coincident with REPORT is ignored. It is accepted only in IDLE.
- rxd activity outside WAIT/RECV is ignored. The echo must not begin before our own stop bit ends.
- Counter widths: sized to hold TIMEOUT_BITS*CLKS_PER_BIT without wrap. The bit counter compares with ==, never relies on overflow.

Test Plan:
1. CLKS_PER_BIT=4, TIMEOUT_BITS=40. Send 0xA5; bench echoes 0xA5 after a 2-bit gap.
   - txd = 0,1,0,1,0,0,1,0,1,1, each 4 cycles.
   - done pulses once; match=1, timeout=0, rx_word=0xA5, err_count=0.
2. Send 0xA5; bench echoes 0x5A -> match=0, rx_word=0x5A, err_count=1.
3. Send 0x3C; rxd held at 1 -> done exactly 160 cycles after end of stop bit; timeout=1, match=0, rx_word=0x00, err_count increments.
4. During WAIT, pulse rxd low for 1 cycle, then send a valid echo 0x3C -> glitch rejected; match=1, no timeout, err_count unchanged.
5. Echo 0x3C with stop bit driven 0 -> match=0 (framing), rx_word=0x3C, err_count increments. Preset err_count to 255 via repeated timeouts, then force another failure -> err_count stays 255.
6. Pulse start again while busy in SEND -> ignored; txd frame unchanged. Then drop rst mid-SEND -> txd=1, busy=0, err_count=0 immediately. After release, a new start runs a clean transaction.
